// File: rtl/nv_ram_fifo_ctrl_80x17_pkg.sv
// Shared sizes, pointer/count types and wrap helpers for the 80x17 RAM FIFO controller.
package nv_ram_fifo_pkg;
  localparam int unsigned DEPTH      = 80;
  localparam int unsigned WIDTH      = 17;
  localparam int unsigned AW         = 7;
  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned SKID_AW    = 2;
  localparam int unsigned PWR_W      = 32;

  typedef logic [AW-1:0]      ptr_t;
  typedef logic [AW-1:0]      cnt_t;
  typedef logic [WIDTH-1:0]   data_t;
  typedef logic [SKID_AW-1:0] skid_ptr_t;
  typedef logic [SKID_AW-1:0] skid_cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic skid_ptr_t skid_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
  endfunction
endpackage

// File: rtl/nv_ram_fifo_ctrl_80x17_if.sv
// Upstream/downstream valid/ready payload ports of the RAM FIFO controller.
interface nv_ram_fifo_ctrl_80x17_if
  import nv_ram_fifo_pkg::*;
();
  logic  wr_pvld;
  logic  wr_prdy;
  data_t wr_pd;
  logic  rd_pvld;
  logic  rd_prdy;
  data_t rd_pd;

  modport master (output wr_pvld, output wr_pd, output rd_prdy,
                  input  wr_prdy, input  rd_pvld, input  rd_pd);
  modport slave  (input  wr_pvld, input  wr_pd, input  rd_prdy,
                  output wr_prdy, output rd_pvld, output rd_pd);
endinterface

// File: rtl/nv_ram_fifo_ctrl_80x17_skid3.sv
// Three-entry circular skid FIFO fed by the RAM read pipeline; head, valid and count are registered.
module nv_ram_fifo_skid3
  import nv_ram_fifo_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  data_t     push_data,
  input  logic      pop,
  output logic      vld,
  output data_t     head,
  output skid_cnt_t cnt
);
  data_t     mem_q [SKID_DEPTH];
  data_t     mem_d [SKID_DEPTH];
  skid_ptr_t wr_ptr_q, wr_ptr_d;
  skid_ptr_t rd_ptr_q, rd_ptr_d;
  skid_cnt_t cnt_q, cnt_d;
  logic      vld_q, vld_d;
  data_t     head_q, head_d;

  // Head is precomputed from the post-update array so rd_pd comes straight from a flop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = skid_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = skid_inc(rd_ptr_q);
    end
    cnt_d  = cnt_q + skid_cnt_t'(push) - skid_cnt_t'(pop);
    vld_d  = (cnt_d != '0);
    head_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
    end
  end

  assign vld  = vld_q;
  assign head = head_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/nv_ram_fifo_ctrl_80x17.sv
// Valid/ready FIFO controller owning both ports of the 80x17 flop RAM; prefetches reads into a 3-entry skid.
module nv_ram_fifo_ctrl_80x17
  import nv_ram_fifo_pkg::*;
(
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  nv_ram_fifo_ctrl_80x17_if.slave bus,
  output cnt_t               ram_count,
  input  logic [PWR_W-1:0]   pwrbus_ram_pd,
  output ptr_t               ram_wa,
  output logic               ram_we,
  output data_t              ram_di,
  output ptr_t               ram_ra,
  output logic               ram_re,
  output logic               ram_ore,
  output logic               ram_byp_sel,
  output data_t              ram_dbyp,
  input  data_t              ram_dout,
  output logic [PWR_W-1:0]   ram_pwrbus_ram_pd
);
  ptr_t      wp_q, wp_d;
  ptr_t      rp_q, rp_d;
  cnt_t      ram_count_q, ram_count_d;
  logic      wr_prdy_q, wr_prdy_d;
  logic      s1_q, s1_d;
  logic      s2_q, s2_d;
  logic      push, pop, issue;
  logic [1:0] inflight;
  logic [2:0] occ;
  logic      skid_vld;
  data_t     skid_head;
  skid_cnt_t skid_cnt;

  // Credit: reads in flight plus skid occupancy after this cycle's pop must leave a free slot.
  always_comb begin
    push        = bus.wr_pvld & wr_prdy_q;
    pop         = skid_vld & bus.rd_prdy;
    inflight    = 2'(s1_q) + 2'(s2_q);
    occ         = 3'(inflight) + 3'(skid_cnt) - 3'(pop);
    issue       = (ram_count_q != '0) && (occ < 3'(SKID_DEPTH));
    wp_d        = push  ? ptr_inc(wp_q) : wp_q;
    rp_d        = issue ? ptr_inc(rp_q) : rp_q;
    ram_count_d = ram_count_q + cnt_t'(push) - cnt_t'(issue);
    wr_prdy_d   = (ram_count_d < cnt_t'(DEPTH));
    s1_d        = issue;
    s2_d        = s1_q;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wp_q        <= '0;
      rp_q        <= '0;
      ram_count_q <= '0;
      wr_prdy_q   <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      ram_count_q <= ram_count_d;
      wr_prdy_q   <= wr_prdy_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  // RAM output register is valid in the cycle s2 is set.
  nv_ram_fifo_skid3 u_skid (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (s2_q),
    .push_data (ram_dout),
    .pop       (pop),
    .vld       (skid_vld),
    .head      (skid_head),
    .cnt       (skid_cnt)
  );

  assign bus.wr_prdy       = wr_prdy_q;
  assign bus.rd_pvld       = skid_vld;
  assign bus.rd_pd         = skid_head;
  assign ram_count         = ram_count_q;
  assign ram_we            = push;
  assign ram_wa            = wp_q;
  assign ram_di            = bus.wr_pd;
  assign ram_re            = issue;
  assign ram_ra            = rp_q;
  assign ram_ore           = s1_q;
  assign ram_byp_sel       = 1'b0;
  assign ram_dbyp          = '0;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x17.sv
// Self-checking bench: vector table for reset/single-word timing, directed corner sequences, random scoreboard run.
module tb_nv_ram_fifo_ctrl_80x17;
  import nv_ram_fifo_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_80x17_if bus ();
  cnt_t        ram_count;
  logic [31:0] pwr, ram_pwr;
  ptr_t        wa, ra;
  logic        we, re, ore, byp_sel;
  data_t       di, dbyp, dout;

  nv_ram_fifo_ctrl_80x17 dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .bus               (bus),
    .ram_count         (ram_count),
    .pwrbus_ram_pd     (pwr),
    .ram_wa            (wa),
    .ram_we            (we),
    .ram_di            (di),
    .ram_ra            (ra),
    .ram_re            (re),
    .ram_ore           (ore),
    .ram_byp_sel       (byp_sel),
    .ram_dbyp          (dbyp),
    .ram_dout          (dout),
    .ram_pwrbus_ram_pd (ram_pwr)
  );

  // Two-stage flop RAM: re latches the address, ore loads the output register.
  data_t mem [DEPTH];
  ptr_t  ra_lat;
  always @(posedge clk) begin
    if (re)  ra_lat <= ra;
    if (ore) dout   <= mem[ra_lat];
    if (we)  mem[wa] <= di;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO queue of accepted words plus modulo-80 address sequences.
  data_t sbq[$];
  logic  prev_stall = 1'b0;
  data_t prev_pd;
  int    exp_wa = 0;
  int    exp_ra = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
      prev_stall = 1'b0;
      exp_wa = 0;
      exp_ra = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld_hold", bus.rd_pvld, 1);
        chk("stall_pd_hold", bus.rd_pd, prev_pd);
      end
      chk("count_le_80", ram_count <= 7'd80, 1);
      chk("occ_ram_le_total", sbq.size() >= int'(ram_count), 1);
      chk("occ_beyond_ram_le_3", (sbq.size() - int'(ram_count)) <= 3, 1);
      if (we) begin
        chk("wa_seq", wa, exp_wa);
        exp_wa = (exp_wa + 1) % DEPTH;
      end
      if (re) begin
        chk("ra_seq", ra, exp_ra);
        exp_ra = (exp_ra + 1) % DEPTH;
      end
      if (bus.rd_pvld && bus.rd_prdy) begin
        if (sbq.size() == 0) begin
          failures++; checks++;
          $display("FAIL pop_empty got=%0h exp=none", bus.rd_pd);
        end else begin
          chk("order", bus.rd_pd, sbq.pop_front());
        end
      end
      if (bus.wr_pvld && bus.wr_prdy) sbq.push_back(bus.wr_pd);
      prev_stall = bus.rd_pvld & ~bus.rd_prdy;
      prev_pd    = bus.rd_pd;
    end
  end

  typedef struct {
    logic  rstn, wv; data_t wd; logic rr;
    logic  e_we; ptr_t e_wa; logic e_re; ptr_t e_ra; logic e_ore;
    logic  e_pv; logic e_pdchk; data_t e_pd; cnt_t e_cnt; logic e_wrdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic wv, input data_t wd, input logic rr,
                              input logic e_we, input logic e_re, input logic e_ore,
                              input logic e_pv, input logic e_pdchk, input data_t e_pd,
                              input cnt_t e_cnt, input logic e_wrdy);
    vec_t v;
    v.rstn = r; v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_we = e_we; v.e_wa = '0; v.e_re = e_re; v.e_ra = '0; v.e_ore = e_ore;
    v.e_pv = e_pv; v.e_pdchk = e_pdchk; v.e_pd = e_pd; v.e_cnt = e_cnt; v.e_wrdy = e_wrdy;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int acc, got, pushed, popped, fpc, lpc, fpo, bubbles, wa79, ra79, lat, extra, cyc;

  initial begin
    #3_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    pwr = 32'hA5A5_1234;
    bus.wr_pvld = 1'b0; bus.wr_pd = '0; bus.rd_prdy = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset rows, then one word pushed into an empty FIFO with rd_prdy high
    vt[0] = mk(1'b0, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h0,     7'd0, 1'b0);
    vt[1] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,     7'd0, 1'b0);
    vt[2] = mk(1'b1, 1'b1, 17'h1ABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,     7'd0, 1'b1);
    vt[3] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h0,     7'd1, 1'b1);
    vt[4] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'h0,     7'd0, 1'b1);
    vt[5] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,     7'd0, 1'b1);
    vt[6] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 17'h1ABCD, 7'd0, 1'b1);
    vt[7] = mk(1'b1, 1'b0, 17'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,     7'd0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      rstn = vt[i].rstn; bus.wr_pvld = vt[i].wv; bus.wr_pd = vt[i].wd; bus.rd_prdy = vt[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_we", i), we, vt[i].e_we);
      if (vt[i].e_we) chk($sformatf("v%0d_wa", i), wa, vt[i].e_wa);
      chk($sformatf("v%0d_re", i), re, vt[i].e_re);
      if (vt[i].e_re) chk($sformatf("v%0d_ra", i), ra, vt[i].e_ra);
      chk($sformatf("v%0d_ore", i), ore, vt[i].e_ore);
      chk($sformatf("v%0d_rd_pvld", i), bus.rd_pvld, vt[i].e_pv);
      if (vt[i].e_pdchk) chk($sformatf("v%0d_rd_pd", i), bus.rd_pd, vt[i].e_pd);
      chk($sformatf("v%0d_count", i), ram_count, vt[i].e_cnt);
      chk($sformatf("v%0d_wr_prdy", i), bus.wr_prdy, vt[i].e_wrdy);
      tick();
    end
    chk("pwrbus_pass", ram_pwr, pwr);
    chk("byp_sel_tied", byp_sel, 0);
    chk("dbyp_tied", dbyp, 0);

    // Fill with downstream stalled: 80 in RAM plus 3 in skid
    bus.rd_prdy = 1'b0; acc = 0;
    for (int i = 0; i < 100; i++) begin
      bus.wr_pvld = 1'b1; bus.wr_pd = data_t'(acc);
      @(negedge clk);
      if (bus.wr_prdy) acc++;
      tick();
    end
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("fill_accepted", acc, 83);
    chk("fill_count", ram_count, 80);
    chk("fill_rd_pvld", bus.rd_pvld, 1);
    chk("fill_head", bus.rd_pd, 0);
    chk("fill_wr_prdy", bus.wr_prdy, 0);
    tick();
    bus.rd_prdy = 1'b1; got = 0;
    for (int c = 0; c < 300 && got < 83; c++) begin
      @(negedge clk);
      if (bus.rd_pvld) begin
        chk("fill_drain_val", bus.rd_pd, got);
        got++;
      end
      tick();
    end
    chk("fill_drained", got, 83);
    repeat (3) tick();

    // Streaming 1/cycle across several pointer wraps
    pushed = 0; popped = 0; bubbles = 0; wa79 = 0; ra79 = 0; fpc = -1; lpc = -1; fpo = -1;
    bus.rd_prdy = 1'b1;
    for (int c = 0; c < 400 && popped < 300; c++) begin
      bus.wr_pvld = (pushed < 300); bus.wr_pd = data_t'(32'h8000 + pushed);
      @(negedge clk);
      if (bus.wr_pvld && bus.wr_prdy) begin
        if (pushed == 0) fpc = c;
        lpc = c;
        pushed++;
      end
      if (bus.rd_pvld) begin
        if (popped == 0) fpo = c;
        popped++;
      end else if (popped > 0) bubbles++;
      if (we && wa == 7'd79) wa79++;
      if (re && ra == 7'd79) ra79++;
      tick();
    end
    bus.wr_pvld = 1'b0;
    chk("stream_pushed", pushed, 300);
    chk("stream_popped", popped, 300);
    chk("stream_push_contig", lpc - fpc, 299);
    chk("stream_latency", fpo - fpc, 4);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_wa_wraps_ge3", wa79 >= 3, 1);
    chk("stream_ra_wraps_ge3", ra79 >= 3, 1);
    repeat (3) tick();

    // Random valid/ready at 50 percent
    pushed = 0; popped = 0;
    for (int c = 0; c < 40000 && popped < 5000; c++) begin
      bus.wr_pvld = (pushed < 5000) && ($urandom_range(0, 1) == 1);
      bus.wr_pd   = data_t'($urandom);
      bus.rd_prdy = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (bus.wr_pvld && bus.wr_prdy) pushed++;
      if (bus.rd_pvld && bus.rd_prdy) popped++;
      tick();
    end
    bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0;
    chk("rand_popped", popped, 5000);
    @(negedge clk);
    chk("rand_sb_empty", sbq.size(), 0);
    chk("rand_count_zero", ram_count, 0);
    tick();

    // Reset with 40 words resident and two reads in flight
    for (int i = 0; i < 45; i++) begin
      bus.wr_pvld = 1'b1; bus.wr_pd = data_t'(32'h100 + i);
      tick();
    end
    bus.wr_pvld = 1'b0;
    repeat (6) tick();
    bus.rd_prdy = 1'b1;
    repeat (2) tick();
    bus.rd_prdy = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("mid_pre_count", ram_count, 40);
    chk("mid_pre_inflight", ore, 1);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rd_pvld", bus.rd_pvld, 0);
    chk("mid_count", ram_count, 0);
    chk("mid_ore", ore, 0);
    chk("mid_re", re, 0);
    tick();
    bus.wr_pvld = 1'b1; bus.wr_pd = 17'h00055;
    @(negedge clk);
    chk("mid_wr_prdy", bus.wr_prdy, 1);
    tick();
    bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b1; lat = -1; extra = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.rd_pvld) begin
        if (lat < 0) begin
          lat = c;
          chk("mid_first_word", bus.rd_pd, 17'h00055);
        end else extra++;
      end
      tick();
    end
    chk("mid_latency", lat, 4);
    chk("mid_no_stale", extra, 0);

    // Boundary: push and issue together with 79 resident
    bus.rd_prdy = 1'b0; cyc = 0;
    bus.wr_pvld = 1'b1;
    for (int c = 0; c < 200; c++) begin
      bus.wr_pd = data_t'(32'h2000 + c);
      @(negedge clk);
      cyc = c;
      tick();
      if (!bus.wr_prdy) break;
    end
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("b79_full_wr_prdy", bus.wr_prdy, 0);
    chk("b79_full_count", ram_count, 80);
    tick();
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    chk("b79_issue", re, 1);
    tick();
    bus.wr_pvld = 1'b1; bus.wr_pd = 17'h1F0F0;
    @(negedge clk);
    chk("b79_count_before", ram_count, 79);
    chk("b79_wr_prdy_before", bus.wr_prdy, 1);
    chk("b79_push", we, 1);
    chk("b79_issue2", re, 1);
    tick();
    bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0;
    @(negedge clk);
    chk("b79_count_after", ram_count, 79);
    chk("b79_wr_prdy_after", bus.wr_prdy, 1);
    tick();
    bus.rd_prdy = 1'b1;
    for (int c = 0; c < 300 && (sbq.size() != 0); c++) tick();
    @(negedge clk);
    chk("b79_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
